usb_in_ep_arbiter: RTL and testbench

Round-robin scheduler that shares the IN protocol engine's single endpoint write port (`in_ep_data_put` / `in_ep_data` / `in_ep_data_done`) among per-endpoint byte-stream sources.
- Grants one endpoint at a time and streams its bytes into that endpoint's packet buffer.
- Closes a packet when it reaches `MAX_IN_PACKET_SIZE` bytes, or with a `done` strobe when the source goes quiet.
- Sits between application FIFOs (e.g. the serial bridge) and the IN protocol engine.

---
 rtl/usb_in_ep_arbiter_if.sv | 28 ++
 rtl/usb_in_ep_arbiter.sv | 153 +++++++++++++++
 tb/tb_usb_in_ep_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_in_ep_arbiter_if.sv
// Purpose : bundles the source-side byte streams and the IN engine write port shared by usb_in_ep_arbiter.
// Latency : none; wiring only.
// Backpressure: src_ready/in_ep_data_put are the per-endpoint handshakes; in_ep_data_free stalls the owner.
// Ports   : master = arbiter side (drives ready/put/data/done/grant/busy); slave = sources + IN engine side.
interface usb_in_ep_arbiter_if #(
   parameter int NUM_IN_EPS = 11
);
   logic [NUM_IN_EPS-1:0]   reset_ep;
   logic [NUM_IN_EPS-1:0]   src_valid;
   logic [8*NUM_IN_EPS-1:0] src_data;
   logic [NUM_IN_EPS-1:0]   src_ready;
   logic [NUM_IN_EPS-1:0]   in_ep_data_free;
   logic [NUM_IN_EPS-1:0]   in_ep_data_put;
   logic [7:0]              in_ep_data;
   logic [NUM_IN_EPS-1:0]   in_ep_data_done;
   logic [NUM_IN_EPS-1:0]   grant;
   logic                    busy;

   modport master (
      input  reset_ep, src_valid, src_data, in_ep_data_free,
      output src_ready, in_ep_data_put, in_ep_data, in_ep_data_done, grant, busy
   );

   modport slave (
      output reset_ep, src_valid, src_data, in_ep_data_free,
      input  src_ready, in_ep_data_put, in_ep_data, in_ep_data_done, grant, busy
   );
endinterface

// File: rtl/usb_in_ep_arbiter.sv
// Purpose : round-robin scheduler sharing the IN engine's single endpoint write port among byte sources.
// Latency : 1 cycle grant after eligibility; then 1 byte/cycle; one dead IDLE cycle between grants.
// Backpressure: put/src_ready follow src_valid & in_ep_data_free combinationally; free low aborts the grant.
// Ports   : clk, reset_n (async active-low), bus (master modport: sources in, engine write port out).
module usb_in_ep_arbiter #(
   parameter int NUM_IN_EPS         = 11,
   parameter int MAX_IN_PACKET_SIZE = 32,
   parameter int FLUSH_TIMEOUT      = 16
) (
   input logic                 clk,
   input logic                 reset_n,
   usb_in_ep_arbiter_if.master bus
);
   localparam int PTR_W  = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
   localparam int CNT_W  = $clog2(MAX_IN_PACKET_SIZE + 1);
   localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t                state;
   logic [NUM_IN_EPS-1:0] grant_q;
   logic [NUM_IN_EPS-1:0] done_q;
   logic                  busy_q;
   logic [PTR_W-1:0]      gidx;
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      next_ptr;
   logic [PTR_W-1:0]      win_idx;
   logic                  win_found;
   logic [CNT_W-1:0]      byte_cnt;
   logic [IDLE_W-1:0]     idle_cnt;
   logic [NUM_IN_EPS-1:0] eligible;
   logic                  g_valid;
   logic                  g_free;
   logic                  g_rst;
   logic [7:0]            g_byte;
   logic                  xfer;

   assign eligible = bus.src_valid & bus.in_ep_data_free & ~bus.reset_ep;

   // Wrapping search from rr_ptr: first pass covers [rr_ptr, N-1], second pass
   // wraps to [0, rr_ptr-1]; the first hit in either pass wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < NUM_IN_EPS; i++) begin
         if (!win_found && eligible[i] && (PTR_W'(i) >= rr_ptr)) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(i);
         end
      end
      for (int i = 0; i < NUM_IN_EPS; i++) begin
         if (!win_found && eligible[i]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(i);
         end
      end
   end

   // Owner's view of the per-endpoint inputs.
   always_comb begin
      g_valid = 1'b0;
      g_free  = 1'b0;
      g_rst   = 1'b0;
      g_byte  = 8'h00;
      for (int i = 0; i < NUM_IN_EPS; i++) begin
         if (gidx == PTR_W'(i)) begin
            g_valid = bus.src_valid[i];
            g_free  = bus.in_ep_data_free[i];
            g_rst   = bus.reset_ep[i];
            g_byte  = bus.src_data[8*i +: 8];
         end
      end
   end

   assign next_ptr = (gidx == PTR_W'(NUM_IN_EPS - 1)) ? '0 : gidx + PTR_W'(1);

   // An endpoint reset suppresses the put even when a byte is on offer.
   assign xfer = (state == STREAM) && g_valid && g_free && !g_rst;

   assign bus.in_ep_data_put  = xfer ? grant_q : '0;
   assign bus.src_ready       = xfer ? grant_q : '0;
   assign bus.in_ep_data      = (state == STREAM) ? g_byte : 8'h00;
   assign bus.in_ep_data_done = done_q;
   assign bus.grant           = grant_q;
   assign bus.busy            = busy_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         grant_q  <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         gidx     <= '0;
         rr_ptr   <= '0;
         byte_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         done_q <= '0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  state    <= STREAM;
                  grant_q  <= NUM_IN_EPS'(1) << win_idx;
                  busy_q   <= 1'b1;
                  gidx     <= win_idx;
                  byte_cnt <= '0;
                  idle_cnt <= '0;
               end
            end
            STREAM: begin
               if (g_rst || !g_free) begin
                  // Bytes already put stay with the engine; no close strobe.
                  state   <= IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  rr_ptr  <= next_ptr;
               end else if (g_valid) begin
                  byte_cnt <= byte_cnt + CNT_W'(1);
                  idle_cnt <= '0;
                  // Full packet: the engine closes it on its own.
                  if (byte_cnt == CNT_W'(MAX_IN_PACKET_SIZE - 1)) begin
                     state   <= IDLE;
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                     rr_ptr  <= next_ptr;
                  end
               end else if (byte_cnt != '0) begin
                  // Reaching the timeout on this edge puts the strobe out next cycle,
                  // i.e. FLUSH_TIMEOUT+1 cycles after the last put.
                  if (idle_cnt == IDLE_W'(FLUSH_TIMEOUT - 1)) begin
                     state    <= DONE;
                     done_q   <= grant_q;
                     idle_cnt <= IDLE_W'(FLUSH_TIMEOUT);
                  end else begin
                     idle_cnt <= idle_cnt + IDLE_W'(1);
                  end
               end
            end
            DONE: begin
               state   <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
               rr_ptr  <= next_ptr;
            end
            default: begin
               state   <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_usb_in_ep_arbiter.sv
// Purpose : directed bench for usb_in_ep_arbiter: table of per-cycle vectors plus multi-cycle sequences.
// Latency : inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: the IN engine is modelled by driving in_ep_data_free directly.
module tb_usb_in_ep_arbiter;
   localparam int N    = 11;
   localparam int MAXP = 32;
   localparam int FT   = 16;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   usb_in_ep_arbiter_if #(.NUM_IN_EPS(N)) bus ();

   usb_in_ep_arbiter #(
      .NUM_IN_EPS(N),
      .MAX_IN_PACKET_SIZE(MAXP),
      .FLUSH_TIMEOUT(FT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [10:0] valid;
      logic [10:0] free;
      logic [10:0] rst;
      logic [10:0] e_grant;
      logic [10:0] e_put;
      logic [10:0] e_done;
      logic [7:0]  e_data;
      logic        e_busy;
      logic [3:0]  e_rr;
   } vec_t;

   vec_t tbl [0:10];

   task automatic do_reset();
      bus.src_valid       = '0;
      bus.reset_ep        = '0;
      bus.in_ep_data_free = '1;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1);
   end

   int   b, last_put, done_at, sent, pkt, hold, dones, done_sent;
   int   order_err, low_put, early_done, bad, puts, n;
   logic full_seen, expect_idle;
   logic [10:0] done_vec, done_put;

   initial begin
      // Sources 1 and 3 compete; closures forced by free drops and an endpoint reset.
      tbl[0]  = '{11'h00A, 11'h7FF, 11'h000, 11'h000, 11'h000, 11'h000, 8'h00, 1'b0, 4'd0};
      tbl[1]  = '{11'h00A, 11'h7FF, 11'h000, 11'h002, 11'h002, 11'h000, 8'hA1, 1'b1, 4'd0};
      tbl[2]  = '{11'h00A, 11'h7FD, 11'h000, 11'h002, 11'h000, 11'h000, 8'hA1, 1'b1, 4'd0};
      tbl[3]  = '{11'h00A, 11'h7FF, 11'h000, 11'h000, 11'h000, 11'h000, 8'h00, 1'b0, 4'd2};
      tbl[4]  = '{11'h00A, 11'h7FF, 11'h000, 11'h008, 11'h008, 11'h000, 8'hA3, 1'b1, 4'd2};
      tbl[5]  = '{11'h00A, 11'h7F7, 11'h000, 11'h008, 11'h000, 11'h000, 8'hA3, 1'b1, 4'd2};
      tbl[6]  = '{11'h00A, 11'h7FF, 11'h000, 11'h000, 11'h000, 11'h000, 8'h00, 1'b0, 4'd4};
      tbl[7]  = '{11'h00A, 11'h7FF, 11'h000, 11'h002, 11'h002, 11'h000, 8'hA1, 1'b1, 4'd4};
      tbl[8]  = '{11'h00A, 11'h7FF, 11'h002, 11'h002, 11'h000, 11'h000, 8'hA1, 1'b1, 4'd4};
      tbl[9]  = '{11'h00A, 11'h7FF, 11'h000, 11'h000, 11'h000, 11'h000, 8'h00, 1'b0, 4'd2};
      tbl[10] = '{11'h00A, 11'h7FF, 11'h000, 11'h008, 11'h008, 11'h000, 8'hA3, 1'b1, 4'd2};

      reset_n             = 1'b0;
      bus.src_valid       = '0;
      bus.reset_ep        = '0;
      bus.in_ep_data_free = '1;
      for (int i = 0; i < N; i++) bus.src_data[i*8 +: 8] = 8'(8'hA0 + i);

      // Reset state
      @(negedge clk);
      #1;
      check("reset grant", 32'(bus.grant), 32'h0);
      check("reset busy", 32'(bus.busy), 32'h0);
      check("reset put", 32'(bus.in_ep_data_put), 32'h0);
      check("reset done", 32'(bus.in_ep_data_done), 32'h0);
      check("reset ready", 32'(bus.src_ready), 32'h0);
      check("reset data", 32'(bus.in_ep_data), 32'h0);
      check("reset rr_ptr", 32'(dut.rr_ptr), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Table-driven arbitration vectors
      for (int r = 0; r <= 10; r++) begin
         @(negedge clk);
         bus.src_valid       = tbl[r].valid;
         bus.in_ep_data_free = tbl[r].free;
         bus.reset_ep        = tbl[r].rst;
         #1;
         check($sformatf("row%0d grant", r), 32'(bus.grant), 32'(tbl[r].e_grant));
         check($sformatf("row%0d put", r), 32'(bus.in_ep_data_put), 32'(tbl[r].e_put));
         check($sformatf("row%0d ready", r), 32'(bus.src_ready), 32'(tbl[r].e_put));
         check($sformatf("row%0d done", r), 32'(bus.in_ep_data_done), 32'(tbl[r].e_done));
         check($sformatf("row%0d data", r), 32'(bus.in_ep_data), 32'(tbl[r].e_data));
         check($sformatf("row%0d busy", r), 32'(bus.busy), 32'(tbl[r].e_busy));
         check($sformatf("row%0d rr_ptr", r), 32'(dut.rr_ptr), 32'(tbl[r].e_rr));
      end

      // Async reset mid-stream (ep3 is putting right now)
      #1;
      reset_n = 1'b0;
      #1;
      check("arst grant", 32'(bus.grant), 32'h0);
      check("arst busy", 32'(bus.busy), 32'h0);
      check("arst put", 32'(bus.in_ep_data_put), 32'h0);
      check("arst ready", 32'(bus.src_ready), 32'h0);
      check("arst data", 32'(bus.in_ep_data), 32'h0);
      check("arst done", 32'(bus.in_ep_data_done), 32'h0);
      @(negedge clk);
      reset_n       = 1'b1;
      bus.src_valid = 11'h009;
      @(negedge clk);
      #1;
      check("restart grant ep0", 32'(bus.grant), 32'h001);
      check("restart put ep0", 32'(bus.in_ep_data_put), 32'h001);

      // ep2: 5 bytes then idle; done 17 cycles after the 5th put
      do_reset();
      b = 0; last_put = -100; done_at = -1; done_vec = '0; done_put = '0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         bus.src_valid[2]    = (b < 5);
         bus.src_data[23:16] = 8'(8'h11 + b);
         #1;
         if (bus.in_ep_data_put[2]) begin
            check("ep2 data", 32'(bus.in_ep_data), 32'(8'(8'h11 + b)));
            b++;
            last_put = c;
         end
         if (bus.in_ep_data_done != '0) begin
            done_at  = c;
            done_vec = bus.in_ep_data_done;
            done_put = bus.in_ep_data_put;
            break;
         end
      end
      check("ep2 put count", 32'(b), 32'd5);
      check("ep2 done delay", 32'(done_at - last_put), 32'd17);
      check("ep2 done vector", 32'(done_vec), 32'h004);
      check("ep2 no put on done", 32'(done_put), 32'h0);
      @(negedge clk);
      #1;
      check("ep2 grant released", 32'(bus.grant), 32'h0);
      check("ep2 busy released", 32'(bus.busy), 32'h0);

      // ep0: 40 bytes, engine drops free for 4 cycles after each full packet
      do_reset();
      sent = 0; pkt = 0; hold = 0; dones = 0; done_sent = -1;
      order_err = 0; low_put = 0; early_done = 0;
      full_seen = 1'b0; expect_idle = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         bus.src_valid[0]  = (sent < 40);
         bus.src_data[7:0] = 8'(sent);
         if (hold > 0) begin
            bus.in_ep_data_free[0] = 1'b0;
            hold--;
         end else begin
            bus.in_ep_data_free[0] = 1'b1;
         end
         #1;
         if (expect_idle) begin
            check("ep0 idle after full packet", 32'(bus.busy), 32'h0);
            expect_idle = 1'b0;
         end
         if (bus.in_ep_data_put[0]) begin
            if (bus.in_ep_data !== 8'(sent)) order_err++;
            if (!bus.in_ep_data_free[0]) low_put++;
            sent++;
            pkt++;
            if (pkt == MAXP) begin
               pkt = 0;
               hold = 4;
               full_seen = 1'b1;
               expect_idle = 1'b1;
            end
         end
         if (bus.in_ep_data_done[0]) begin
            dones++;
            done_sent = sent;
            if (!full_seen) early_done++;
            break;
         end
      end
      check("ep0 total puts", 32'(sent), 32'd40);
      check("ep0 byte order errors", 32'(order_err), 32'd0);
      check("ep0 puts while not free", 32'(low_put), 32'd0);
      check("ep0 done count", 32'(dones), 32'd1);
      check("ep0 done after byte 40", 32'(done_sent), 32'd40);
      check("ep0 done before full packet", 32'(early_done), 32'd0);

      // ep4: free drops after 3 puts -> abort, no done
      do_reset();
      puts = 0;
      bus.src_valid[4]     = 1'b1;
      bus.src_data[39:32]  = 8'h44;
      for (int c = 0; c < 20 && puts < 3; c++) begin
         @(negedge clk);
         #1;
         if (bus.in_ep_data_put[4]) puts++;
      end
      check("ep4 puts before stall", 32'(puts), 32'd3);
      @(negedge clk);
      bus.in_ep_data_free[4] = 1'b0;
      #1;
      check("ep4 stall put", 32'(bus.in_ep_data_put), 32'h0);
      check("ep4 stall ready", 32'(bus.src_ready[4]), 32'h0);
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         if (bus.src_ready[4] || bus.in_ep_data_put != '0 || bus.in_ep_data_done != '0) bad++;
      end
      check("ep4 quiet after abort", 32'(bad), 32'd0);
      check("ep4 grant after abort", 32'(bus.grant), 32'h0);

      // ep6: endpoint reset on a put cycle
      do_reset();
      puts = 0;
      bus.src_valid[6]    = 1'b1;
      bus.src_data[55:48] = 8'h66;
      for (int c = 0; c < 10 && puts < 1; c++) begin
         @(negedge clk);
         #1;
         if (bus.in_ep_data_put[6]) puts++;
      end
      check("ep6 first put", 32'(puts), 32'd1);
      @(negedge clk);
      bus.reset_ep[6] = 1'b1;
      #1;
      check("ep6 reset put", 32'(bus.in_ep_data_put), 32'h0);
      check("ep6 reset ready", 32'(bus.src_ready), 32'h0);
      @(negedge clk);
      #1;
      check("ep6 grant after reset", 32'(bus.grant), 32'h0);

      // ep5: a byte arriving on the timeout cycle wins over the close
      do_reset();
      puts = 0;
      bus.src_valid[5]    = 1'b1;
      bus.src_data[47:40] = 8'h55;
      for (int c = 0; c < 10 && puts < 1; c++) begin
         @(negedge clk);
         #1;
         if (bus.in_ep_data_put[5]) puts++;
      end
      check("ep5 first put", 32'(puts), 32'd1);
      bad = 0;
      for (int c = 0; c < FT - 1; c++) begin
         @(negedge clk);
         bus.src_valid[5] = 1'b0;
         #1;
         if (bus.in_ep_data_done != '0) bad++;
      end
      @(negedge clk);
      bus.src_valid[5]    = 1'b1;
      bus.src_data[47:40] = 8'h56;
      #1;
      check("ep5 early done", 32'(bad), 32'd0);
      check("ep5 late byte put", 32'(bus.in_ep_data_put), 32'h020);
      check("ep5 late byte data", 32'(bus.in_ep_data), 32'h56);
      check("ep5 no done on collision", 32'(bus.in_ep_data_done), 32'h0);
      n = -1;
      for (int c = 1; c < 40; c++) begin
         @(negedge clk);
         bus.src_valid[5] = 1'b0;
         #1;
         if (bus.in_ep_data_done != '0) begin
            n = c;
            break;
         end
      end
      check("ep5 done delay", 32'(n), 32'd17);
      check("ep5 done vector", 32'(bus.in_ep_data_done), 32'h020);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
